cdb_arbiter: RTL

//  Shares the single Common Data Bus among NUM_REQ functional units writing results back to the ROB/RS.

---
 rtl/cdb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single Common Data Bus among NUM_REQ functional units.
// Each requester owns a one-entry holding buffer so the FU can hand off a result
// and move on. Full buffers are granted round-robin, one per cycle, into a
// registered CDB output that feeds the ROB and reservation stations.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic [NUM_REQ*XLEN-1:0]  req_value,
  input  logic [NUM_REQ-1:0]       req_has_dest,
  input  logic [NUM_REQ-1:0]       req_mispredict,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]          cdb_value,
  output logic                     cdb_has_dest,
  output logic                     cdb_mispredict
);

  localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so rr_ptr + offset can be wrapped without overflow.
  localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);

  // Holding buffers, one per requester.
  logic [NUM_REQ-1:0] buf_valid_r;
  logic [TAG_W-1:0]   buf_tag_r   [NUM_REQ];
  logic [XLEN-1:0]    buf_value_r [NUM_REQ];
  logic [NUM_REQ-1:0] buf_has_dest_r;
  logic [NUM_REQ-1:0] buf_mispredict_r;

  // Round-robin pointer: the first index searched in the next arbitration.
  logic [PTR_W-1:0]   rr_ptr_r;

  // Arbitration results for the current cycle.
  logic [NUM_REQ-1:0] grant_s;
  logic               grant_any_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [PTR_W:0]     cand_s;
  logic               hit_s;

  // Handshake signals.
  logic [NUM_REQ-1:0] req_ready_s;
  logic [NUM_REQ-1:0] load_s;

  // Registered CDB broadcast.
  logic               cdb_valid_r;
  logic [TAG_W-1:0]   cdb_tag_r;
  logic [XLEN-1:0]    cdb_value_r;
  logic               cdb_has_dest_r;
  logic               cdb_mispredict_r;

  // Round-robin search over full buffers starting at rr_ptr; squash blocks every grant.
  always_comb begin
    grant_s     = '0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      cand_s      = (cand_s >= NUM_REQ_W) ? (cand_s - NUM_REQ_W) : cand_s;
      hit_s       = buf_valid_r[cand_s[PTR_W-1:0]] & ~grant_any_s & ~squash;
      grant_s[cand_s[PTR_W-1:0]] = grant_s[cand_s[PTR_W-1:0]] | hit_s;
      grant_idx_s = hit_s ? cand_s[PTR_W-1:0] : grant_idx_s;
      grant_any_s = grant_any_s | hit_s;
    end
  end

  // A buffer can accept when empty or being drained this cycle; squash accepts and drops everything.
  always_comb begin
    if (squash) begin
      req_ready_s = '1;
    end else begin
      req_ready_s = ~buf_valid_r | grant_s;
    end
    load_s = req_valid & req_ready_s;
  end

  assign req_ready = req_ready_s;

  // Holding buffers: refill on transfer (new data wins over a same-cycle grant), clear when drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid_r      <= '0;
      buf_has_dest_r   <= '0;
      buf_mispredict_r <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_tag_r[i]   <= '0;
        buf_value_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (squash) begin
          buf_valid_r[i] <= 1'b0;
        end else if (load_s[i]) begin
          buf_valid_r[i]      <= 1'b1;
          buf_tag_r[i]        <= req_tag[i*TAG_W +: TAG_W];
          buf_value_r[i]      <= req_value[i*XLEN +: XLEN];
          buf_has_dest_r[i]   <= req_has_dest[i];
          buf_mispredict_r[i] <= req_mispredict[i];
        end else if (grant_s[i]) begin
          buf_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // CDB output register and round-robin pointer advance past the granted buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_r         <= '0;
      cdb_valid_r      <= 1'b0;
      cdb_tag_r        <= '0;
      cdb_value_r      <= '0;
      cdb_has_dest_r   <= 1'b0;
      cdb_mispredict_r <= 1'b0;
    end else if (squash) begin
      rr_ptr_r         <= '0;
      cdb_valid_r      <= 1'b0;
      cdb_tag_r        <= '0;
      cdb_value_r      <= '0;
      cdb_has_dest_r   <= 1'b0;
      cdb_mispredict_r <= 1'b0;
    end else if (grant_any_s) begin
      rr_ptr_r         <= (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + PTR_W'(1));
      cdb_valid_r      <= 1'b1;
      cdb_tag_r        <= buf_tag_r[grant_idx_s];
      cdb_value_r      <= buf_value_r[grant_idx_s];
      cdb_has_dest_r   <= buf_has_dest_r[grant_idx_s];
      cdb_mispredict_r <= buf_mispredict_r[grant_idx_s];
    end else begin
      cdb_valid_r      <= 1'b0;
      cdb_tag_r        <= '0;
      cdb_value_r      <= '0;
      cdb_has_dest_r   <= 1'b0;
      cdb_mispredict_r <= 1'b0;
    end
  end

  assign cdb_valid      = cdb_valid_r;
  assign cdb_tag        = cdb_tag_r;
  assign cdb_value      = cdb_value_r;
  assign cdb_has_dest   = cdb_has_dest_r;
  assign cdb_mispredict = cdb_mispredict_r;

endmodule
